// File: rtl/pipelined_adder_pkg.sv
// Shared types for the slice-pipelined adder: operation select, per-stage payload
// and the signed-overflow helper.
package pipelined_adder_pkg;

    // Widest operand the stage payload can carry; narrower configurations leave the
    // upper bits constant and they are trimmed away.
    localparam int unsigned MAX_N_BIT = 256;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    typedef struct packed {
        logic                 valid;
        op_t                  op;
        logic                 carry;
        logic [MAX_N_BIT-1:0] sum;
        logic [MAX_N_BIT-1:0] opa;
        logic [MAX_N_BIT-1:0] opb;
    } stage_t;

    function automatic logic signed_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb
    );
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipelined_tree_adder_stage.sv
// One SLICE_BIT-wide combinational adder slice with carry in and carry out.
module adder_pipe_stage #(
    parameter int unsigned SLICE_BIT = 8
) (
    input  logic [SLICE_BIT-1:0] a,
    input  logic [SLICE_BIT-1:0] b,
    input  logic                 carry_in,
    output logic [SLICE_BIT-1:0] sum_c,
    output logic                 carry_out_c
);

    localparam int unsigned SUM_W = SLICE_BIT + 1;

    logic [SUM_W-1:0] total;

    assign total       = {1'b0, a} + {1'b0, b} + SUM_W'(carry_in);
    assign sum_c       = total[SLICE_BIT-1:0];
    assign carry_out_c = total[SLICE_BIT];

endmodule

// File: rtl/pipelined_tree_adder.sv
// Carry-skewed pipelined adder/subtractor: one SLICE_BIT slice per stage, global
// valid/ready advance, operand slices travel with the partially built sum.
module pipelined_tree_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned N_BIT     = 32,
    parameter int unsigned SLICE_BIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_BIT-1:0] operand_1,
    input  logic [N_BIT-1:0] operand_2,
    input  logic             carry_in,
    input  op_t              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_BIT-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NS = N_BIT / SLICE_BIT;

    if ((SLICE_BIT != 4 && SLICE_BIT != 8 && SLICE_BIT != 16) || N_BIT < 8 ||
        (N_BIT % SLICE_BIT) != 0 || N_BIT > MAX_N_BIT) begin : g_bad_params
        $error("pipelined_tree_adder: illegal N_BIT/SLICE_BIT combination");
    end

    stage_t               stage_q [NS];
    stage_t               stage_d [NS];
    logic [SLICE_BIT-1:0] slice_a   [NS];
    logic [SLICE_BIT-1:0] slice_b   [NS];
    logic [SLICE_BIT-1:0] slice_sum [NS];
    logic                 slice_cin  [NS];
    logic                 slice_cout [NS];

    logic             advance;
    logic             accept;
    logic [N_BIT-1:0] opb_eff;
    logic             cin_eff;
    logic             zero_q;
    logic             zero_d;
    logic             overflow_q;
    logic             overflow_d;

    // Reset forces readiness even when a stalled result sits in the last stage.
    assign advance  = !stage_q[NS-1].valid || out_ready;
    assign in_ready = advance || rst;
    assign accept   = in_valid && in_ready;

    // Subtraction is a + ~b + 1, so the forced carry replaces carry_in.
    assign opb_eff = (op == OP_SUB) ? ~operand_2 : operand_2;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : carry_in;

    for (genvar k = 0; k < NS; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign slice_a[k]   = operand_1[SLICE_BIT-1:0];
            assign slice_b[k]   = opb_eff[SLICE_BIT-1:0];
            assign slice_cin[k] = cin_eff;
        end else begin : g_next
            assign slice_a[k]   = stage_q[k-1].opa[k*SLICE_BIT +: SLICE_BIT];
            assign slice_b[k]   = stage_q[k-1].opb[k*SLICE_BIT +: SLICE_BIT];
            assign slice_cin[k] = stage_q[k-1].carry;
        end

        adder_pipe_stage #(
            .SLICE_BIT (SLICE_BIT)
        ) u_slice (
            .a           (slice_a[k]),
            .b           (slice_b[k]),
            .carry_in    (slice_cin[k]),
            .sum_c       (slice_sum[k]),
            .carry_out_c (slice_cout[k])
        );
    end

    // Next contents of every stage; payload only reloads behind a valid entry so
    // bubbles never disturb the presented result.
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            stage_d[k] = stage_q[k];
        end

        stage_d[0].valid = accept;
        if (accept) begin
            stage_d[0].op    = op;
            stage_d[0].carry = slice_cout[0];
            stage_d[0].sum   = MAX_N_BIT'(slice_sum[0]);
            stage_d[0].opa   = MAX_N_BIT'(operand_1);
            stage_d[0].opb   = MAX_N_BIT'(opb_eff);
        end

        for (int k = 1; k < NS; k++) begin
            stage_d[k].valid = stage_q[k-1].valid;
            if (stage_q[k-1].valid) begin
                stage_d[k].op    = stage_q[k-1].op;
                stage_d[k].carry = slice_cout[k];
                stage_d[k].opa   = stage_q[k-1].opa;
                stage_d[k].opb   = stage_q[k-1].opb;
                stage_d[k].sum   = stage_q[k-1].sum;
                stage_d[k].sum[k*SLICE_BIT +: SLICE_BIT] = slice_sum[k];
            end
        end

        zero_d     = (stage_d[NS-1].sum[N_BIT-1:0] == '0);
        overflow_d = signed_overflow(stage_d[NS-1].opa[N_BIT-1],
                                     stage_d[NS-1].opb[N_BIT-1],
                                     stage_d[NS-1].sum[N_BIT-1]);
    end

    // Stage registers and registered result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NS; k++) begin
                stage_q[k] <= '0;
            end
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NS; k++) begin
                stage_q[k] <= stage_d[k];
            end
            if (stage_d[NS-1].valid) begin
                zero_q     <= zero_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign out_valid = stage_q[NS-1].valid;
    assign sum       = stage_q[NS-1].sum[N_BIT-1:0];
    assign carry_out = stage_q[NS-1].carry;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_tree_adder.sv
// Scoreboard bench for pipelined_tree_adder (32-bit, 8-bit slices): directed corner
// sums, back-to-back streaming, output stall, mid-flight reset and random traffic.
module tb_pipelined_tree_adder;
    import pipelined_adder_pkg::*;

    localparam int unsigned N_BIT     = 32;
    localparam int unsigned SLICE_BIT = 8;
    localparam int unsigned NS        = N_BIT / SLICE_BIT;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        carry_in;
    op_t         op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        ov;
        logic        z;
        int          cyc;
    } exp_t;

    typedef struct {
        op_t         o;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        c;
        logic        ov;
        logic        z;
    } dir_t;

    exp_t        exp_q[$];
    dir_t        dirs[4];
    exp_t        dir_exp;
    logic        dir_en       = 1'b0;
    logic        check_lat    = 1'b0;
    logic        expect_stall = 1'b0;
    logic        expect_idle  = 1'b0;
    logic        hold_prev    = 1'b0;
    logic [34:0] prev_out     = '0;
    int          cyc          = 0;
    int          n_out        = 0;
    int          n_checks     = 0;
    int          n_fail       = 0;

    pipelined_tree_adder #(
        .N_BIT     (N_BIT),
        .SLICE_BIT (SLICE_BIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .carry_in  (carry_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input op_t o, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci);
        exp_t        m;
        logic [31:0] bb;
        logic [32:0] r;
        bb   = (o == OP_SUB) ? ~b : b;
        r    = {1'b0, a} + {1'b0, bb} + 33'((o == OP_SUB) ? 1'b1 : ci);
        m.s  = r[31:0];
        m.c  = r[32];
        m.ov = (a[31] == bb[31]) && (r[31] != a[31]);
        m.z  = (r[31:0] == 32'd0);
        m.cyc = 0;
        return m;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Observe one cycle at the falling edge: retire against the scoreboard, then record acceptance.
    task automatic monitor();
        exp_t e;
        if (rst) begin
            check("rdy_in_rst", 64'(in_ready), 64'(1));
            exp_q.delete();
            hold_prev = 1'b0;
            return;
        end
        if (hold_prev)
            check("hold", 64'({sum, carry_out, overflow, zero}), 64'(prev_out));
        if (expect_stall)
            check("stall_rdy", 64'(in_ready), 64'(0));
        if (expect_idle) begin
            check("flush_valid", 64'(out_valid), 64'(0));
            check("flush_sum", 64'(sum), 64'(0));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                n_out++;
                check("sum", 64'(sum), 64'(e.s));
                check("flags_c_ov_z", 64'({carry_out, overflow, zero}), 64'({e.c, e.ov, e.z}));
                if (check_lat)
                    check("latency", 64'(cyc - e.cyc), 64'(NS));
            end
        end
        hold_prev = out_valid && !out_ready;
        prev_out  = {sum, carry_out, overflow, zero};
        if (in_valid && in_ready) begin
            e     = dir_en ? dir_exp : model(op, operand_1, operand_2, carry_in);
            e.cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input logic v, input op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic ordy, input logic r);
        rst       = r;
        in_valid  = v;
        op        = o;
        operand_1 = a;
        operand_2 = b;
        carry_in  = ci;
        out_ready = ordy;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, ordy, 1'b0);
    endtask

    task automatic rand_op(input logic ordy);
        step(1'b1, op_t'(1'($urandom_range(0, 1))), rand_word(), rand_word(),
             1'($urandom_range(0, 1)), ordy, 1'b0);
    endtask

    task automatic directed(input int idx);
        dir_exp.s  = dirs[idx].s;
        dir_exp.c  = dirs[idx].c;
        dir_exp.ov = dirs[idx].ov;
        dir_exp.z  = dirs[idx].z;
        dir_en     = 1'b1;
        step(1'b1, dirs[idx].o, dirs[idx].a, dirs[idx].b, dirs[idx].ci, 1'b1, 1'b0);
        dir_en     = 1'b0;
        repeat (6) idle(1'b1);
    endtask

    initial begin
        dirs[0] = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        dirs[1] = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        dirs[2] = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        dirs[3] = '{OP_ADD, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; op = OP_ADD; operand_1 = '0; operand_2 = '0;
        carry_in = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) step(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_flags", 64'({carry_out, overflow, zero}), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(1));

        // Directed corner cases with latency checking.
        check_lat = 1'b1;
        for (int i = 0; i < 3; i++) directed(i);

        // Ten back-to-back operations, consumer always ready.
        n_out = 0;
        repeat (10) rand_op(1'b1);
        repeat (6) idle(1'b1);
        check("b2b_count", 64'(n_out), 64'(10));

        // Fill the pipeline, stall the consumer for six cycles, then drain.
        check_lat = 1'b0;
        repeat (NS) rand_op(1'b0);
        expect_stall = 1'b1;
        repeat (6) rand_op(1'b0);
        expect_stall = 1'b0;
        repeat (8) idle(1'b1);
        check("stall_drain", 64'(exp_q.size()), 64'(0));

        // Reset with three operations in flight; nothing stale may emerge.
        check_lat = 1'b1;
        repeat (3) rand_op(1'b1);
        repeat (2) step(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        expect_idle = 1'b1;
        repeat (6) idle(1'b1);
        expect_idle = 1'b0;
        directed(3);

        // Random traffic with random back-pressure.
        check_lat = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) != 0) rand_op(1'($urandom_range(0, 3) != 0));
            else idle(1'($urandom_range(0, 1)));
        end
        repeat (12) idle(1'b1);
        check("final_drain", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
